lsu_bus_master: RTL
===================

// Module: lsu_bus_master
// PURPOSE
//  Parametrised multi-cycle load/store bus master for the riscv64 core. Replaces the hard-wired keyboard-load
//  sequence (two-step lb_step) with a general LSU for all access sizes. Accepts one request at a time from EXE,
//  drives the memory/MMIO bus with byte enables, and tolerates wait states. Returns sign/zero-extended read
//  data or an error (misaligned or timeout). Sits between the core EXE stage and the system bus decoder.
// PARAMETERS
//  XLEN        64  data width, 32 or 64; bus data width = XLEN, NB = XLEN/8 byte lanes
//  ADDR_W      64  address width
//  TIMEOUT     255 max ACCESS cycles before error; 0 = never time out
// PORTS
//  clk             in   1       clock, all state on rising edge
//  reset           in   1       asynchronous, active-low reset
//  req_valid       in   1       EXE presents a request
//  req_ready       out  1       LSU can accept (1 only in IDLE)
//  req_we          in   1       1 = store, 0 = load
//  req_size        in   2       0=B 1=H 2=W 3=D
//  req_unsigned    in   1       loads: 1 = zero-extend, 0 = sign-extend
//  req_addr        in   ADDR_W  byte address
//  req_wdata       in   XLEN    store data, right-justified
//  rsp_valid       out  1       one-cycle response pulse
//  rsp_rdata       out  XLEN    extended load data; 0 for stores/errors
//  rsp_err         out  1       valid with rsp_valid: misaligned/timeout/unsupported size
//  busy            out  1       ~req_ready; EXE holds pc and bubbles while high
//  bus_address     out  ADDR_W  req_addr with low log2(NB) bits cleared
//  bus_write_data  out  XLEN    store data replicated into addressed lanes
//  bus_byte_enable out  NB      active lanes
//  bus_write_enable out 1       store strobe
//  bus_read_enable out  1       load strobe
//  bus_read_data   in   XLEN    read data, valid when bus_ready=1
//  bus_ready       in   1       slave completes current access this cycle
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=1; rsp_valid=0; rsp_err=0; rsp_rdata=0; bus_* enables=0; byte_enable=0;
//    bus_address=0; bus_write_data=0; timeout counter=0. Reset mid-access drops strobes at once (async).
//  FSM IDLE -> ACCESS -> RESP -> IDLE; IDLE -> RESP directly on error-at-accept.
//  IDLE: on req_valid&&req_ready latch all req_* fields. Error-at-accept when misaligned (H: addr[0];
//    W: addr[1:0]!=0; D: addr[2:0]!=0) or size D with XLEN=32 -> RESP with err=1, no bus strobe ever.
//    Else -> ACCESS; strobe, address, byte_enable, write_data registered, valid the cycle after accept.
//  ACCESS: strobes held stable until bus_ready=1 sampled. On that edge: strobes/byte_enable -> 0,
//    load data extracted from lane addr[log2(NB)-1:0], extended per size/unsigned, registered -> RESP.
//  Timeout: counter increments each ACCESS cycle without bus_ready; when it reaches TIMEOUT with no
//    bus_ready, drop strobes -> RESP with err=1, rdata=0. bus_ready in the same cycle wins over timeout.
//  RESP: rsp_valid=1 for exactly one cycle, rsp_err/rsp_rdata stable that cycle -> IDLE. rsp_rdata and
//    rsp_err cleared to 0 when rsp_valid falls.
//  Latency: zero-wait access = accept edge N, strobe cycle N+1, rsp_valid cycle N+2, req_ready again N+3.
//  Error-at-accept: rsp_valid cycle N+1.
//  Byte enables: B=1<<off, H=3<<off, W=0xF<<off, D=0xFF; write_data = wdata replicated at every size granule.
//  Width: all extension done at XLEN; bus_read_data bits outside active lanes are ignored.
//  req_valid outside IDLE is ignored (no queue); request fields may change freely after acceptance.
// STRUCTURE
//  Shared package lsu_pkg: SIZE_B/H/W/D localparams, lsu_state_t (IDLE, ACCESS, RESP) encoding,
//    function is_misaligned(size, addr_lo).
//  One combinational sub-module lsu_lane_align: byte_enable + write replication for stores,
//    lane extraction + sign/zero extension for loads. FSM, counter and registers stay in lsu_bus_master.
// TESTING
//  1 LB addr=0x8000_0013, bus_read_data=0x0000_0000_8000_0000 (byte3=0x80), ready same cycle ->
//    byte_enable=0x08, rsp_rdata=0xFFFF_FFFF_FFFF_FF80, rsp_valid at N+2.
//  2 SH addr=0x...06, wdata=0xBEEF -> byte_enable=0xC0, write_data=0xBEEF_BEEF_BEEF_BEEF,
//    rsp_err=0, rsp_rdata=0.
//  3 LW unsigned addr=0x...02 -> rsp_valid at N+1 with rsp_err=1; bus_read_enable never asserts.
//  4 LD, bus_ready held low 3 cycles then 1 -> strobe stable 4 cycles, address unchanged, correct 64-bit data.
//  5 TIMEOUT=4, bus_ready never asserted -> strobe drops after 4 ACCESS cycles, rsp_err=1, rsp_rdata=0.
//  6 reset low during ACCESS -> strobes 0 immediately, req_ready=1 after release, next request completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store bus master.
//   SIZE_*        access size encodings carried on req_size
//   lsu_state_t   FSM states (IDLE, ACCESS, RESP)
//   is_misaligned natural-alignment check for a size and the low address bits
package lsu_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] addr_lo);
    case (size)
      SIZE_H:  return addr_lo[0];
      SIZE_W:  return addr_lo[1:0] != 2'b00;
      SIZE_D:  return addr_lo != 3'b000;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering for the load/store bus master.
//   size, offset   access size and byte offset within the bus word
//   is_unsigned    loads: zero-extend instead of sign-extend
//   wdata          right-justified store data
//   rdata          raw bus read data
//   byte_enable    active lanes for the access
//   write_data     store data replicated at every size granule
//   load_data      addressed lanes extracted and extended to XLEN
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [1:0]                 size,
  input  logic                       is_unsigned,
  input  logic [$clog2(XLEN/8)-1:0]  offset,
  input  logic [XLEN-1:0]            wdata,
  input  logic [XLEN-1:0]            rdata,
  output logic [XLEN/8-1:0]          byte_enable,
  output logic [XLEN-1:0]            write_data,
  output logic [XLEN-1:0]            load_data
);

  localparam int unsigned NB = XLEN / 8;

  logic [3:0]      gran;
  logic [XLEN-1:0] shifted;
  logic            sign;

  always_comb begin
    gran = 4'd1;
    case (size)
      SIZE_B:  gran = 4'd1;
      SIZE_H:  gran = 4'd2;
      SIZE_W:  gran = 4'd4;
      default: gran = 4'd8;
    endcase
    if (gran > 4'(NB)) gran = 4'(NB);
  end

  // gran is a power of two, so masking with gran-1 picks the source byte
  // of the granule each lane repeats.
  always_comb begin
    byte_enable = '0;
    write_data  = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      byte_enable[i]       = (i >= 32'(offset)) && (i < 32'(offset) + 32'(gran));
      write_data[8*i +: 8] = wdata[8*(i & 32'(gran - 4'd1)) +: 8];
    end
  end

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    case (size)
      SIZE_B:  sign = shifted[7];
      SIZE_H:  sign = shifted[15];
      SIZE_W:  sign = shifted[31];
      default: sign = shifted[XLEN-1];
    endcase
    sign      = sign & ~is_unsigned;
    load_data = '0;
    for (int unsigned i = 0; i < XLEN; i++) begin
      load_data[i] = (i < 8 * 32'(gran)) ? shifted[i] : sign;
    end
  end

endmodule

// File: rtl/lsu_bus_master.sv
// Multi-cycle load/store bus master between the EXE stage and the bus decoder.
// Takes one request at a time, drives a wait-state tolerant bus with byte
// enables and returns extended load data or an error.
//   clk, reset            clock; asynchronous active-low reset
//   req_*                 request from EXE (accepted only while req_ready)
//   rsp_valid/rdata/err   one-cycle response pulse
//   busy                  inverse of req_ready
//   bus_*                 registered bus strobes, address, lanes; bus_ready ends an access
module lsu_bus_master
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  output logic                rsp_valid,
  output logic [XLEN-1:0]     rsp_rdata,
  output logic                rsp_err,
  output logic                busy,
  output logic [ADDR_W-1:0]   bus_address,
  output logic [XLEN-1:0]     bus_write_data,
  output logic [XLEN/8-1:0]   bus_byte_enable,
  output logic                bus_write_enable,
  output logic                bus_read_enable,
  input  logic [XLEN-1:0]     bus_read_data,
  input  logic                bus_ready
);

  localparam int unsigned NB    = XLEN / 8;
  localparam int unsigned OFF_W = $clog2(NB);

  lsu_state_t          state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]     wdata_q, wdata_d;
  logic [NB-1:0]       be_q, be_d;
  logic                we_q, we_d;
  logic                re_q, re_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic [OFF_W-1:0]    off_q, off_d;
  logic [31:0]         tcount_q, tcount_d;

  logic [1:0]          al_size;
  logic [OFF_W-1:0]    al_off;
  logic [NB-1:0]       al_be;
  logic [XLEN-1:0]     al_wdata;
  logic [XLEN-1:0]     al_load;
  logic                err_at_accept;

  // One aligner serves both directions: in IDLE it sees the incoming request
  // (store lanes), during ACCESS the latched request (load extraction).
  assign al_size = (state_q == IDLE) ? req_size : size_q;
  assign al_off  = (state_q == IDLE) ? req_addr[OFF_W-1:0] : off_q;

  lsu_lane_align #(.XLEN(XLEN)) u_align (
    .size        (al_size),
    .is_unsigned (uns_q),
    .offset      (al_off),
    .wdata       (req_wdata),
    .rdata       (bus_read_data),
    .byte_enable (al_be),
    .write_data  (al_wdata),
    .load_data   (al_load)
  );

  assign err_at_accept = is_misaligned(req_size, req_addr[2:0]) ||
                         ((XLEN == 32) && (req_size == SIZE_D));

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    we_d        = we_q;
    re_d        = re_q;
    size_d      = size_q;
    uns_d       = uns_q;
    off_d       = off_q;
    tcount_d    = tcount_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        tcount_d = '0;
        if (req_valid) begin
          size_d = req_size;
          uns_d  = req_unsigned;
          off_d  = req_addr[OFF_W-1:0];
          if (err_at_accept) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d = ACCESS;
            addr_d  = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            wdata_d = req_we ? al_wdata : '0;
            be_d    = al_be;
            we_d    = req_we;
            re_d    = ~req_we;
          end
        end
      end
      ACCESS: begin
        // bus_ready takes priority over an expiring timeout in the same cycle.
        if (bus_ready) begin
          state_d     = RESP;
          we_d        = 1'b0;
          re_d        = 1'b0;
          be_d        = '0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = re_q ? al_load : '0;
        end else if ((TIMEOUT != 0) && (tcount_q + 32'd1 == 32'(TIMEOUT))) begin
          state_d     = RESP;
          we_d        = 1'b0;
          re_d        = 1'b0;
          be_d        = '0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else begin
          tcount_d = tcount_q + 32'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      off_q       <= '0;
      tcount_q    <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      we_q        <= we_d;
      re_q        <= re_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      off_q       <= off_d;
      tcount_q    <= tcount_d;
    end
  end

  assign req_ready        = (state_q == IDLE);
  assign busy             = ~req_ready;
  assign rsp_valid        = rsp_valid_q;
  assign rsp_rdata        = rsp_rdata_q;
  assign rsp_err          = rsp_err_q;
  assign bus_address      = addr_q;
  assign bus_write_data   = wdata_q;
  assign bus_byte_enable  = be_q;
  assign bus_write_enable = we_q;
  assign bus_read_enable  = re_q;

endmodule
